// File: rtl/mem_xfer_pkg.sv
// Shared constants and FSM state encoding for the mem_xfer block-transfer engine.
package mem_xfer_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPT,
        RD_HOLD,
        WR_WAIT,
        WR_ISSUE,
        DONE
    } state_t;

endpackage

// File: rtl/xfer_addr_gen.sv
// Base/index registers for one transfer: registered word address (wraps at 2^AW) and last-word flag.
module xfer_addr_gen
    import mem_xfer_pkg::*;
#(
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned LW = LEN_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base_in,
    input  logic [LW-1:0] len_in,
    output logic [AW-1:0] addr,
    output logic          last_c
);

    logic [AW-1:0] base_q;
    logic [AW-1:0] base_d;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [LW-1:0] idx_d;

    always_comb begin
        base_d = base_q;
        idx_d  = idx_q;
        if (load) begin
            base_d = base_in;
            idx_d  = '0;
        end else if (step) begin
            idx_d = idx_q + LW'(1);
        end
    end

    // addr tracks base+idx of the values about to be registered, so it is valid in the issue cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            addr   <= '0;
        end else begin
            base_q <= base_d;
            idx_q  <= idx_d;
            if (load) begin
                len_q <= len_in;
            end
            addr <= AW'(base_d + AW'(idx_d));
        end
    end

    assign last_c = (({1'b0, idx_q} + (LW+1)'(1)) == {1'b0, len_q});

endmodule

// File: rtl/mem_xfer.sv
// Moves cmdLen words between a single-port memory and a valid/ready stream, one word at a time.
module mem_xfer #(
    parameter int unsigned ADDR_W = mem_xfer_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_xfer_pkg::DATA_W,
    parameter int unsigned LEN_W  = mem_xfer_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdRW,
    input  logic [ADDR_W-1:0] cmdBase,
    input  logic [LEN_W-1:0]  cmdLen,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    input  logic              rdReady,
    input  logic [DATA_W-1:0] wrData,
    input  logic              wrValid,
    output logic              wrReady,
    output logic              done,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRW,
    output logic              memEN,
    output logic [DATA_W-1:0] memWrite,
    input  logic [DATA_W-1:0] memBus
);
    import mem_xfer_pkg::*;

    state_t state_q;
    state_t state_d;
    logic   load;
    logic   step;
    logic   last_c;

    xfer_addr_gen #(
        .AW (ADDR_W),
        .LW (LEN_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .base_in (cmdBase),
        .len_in  (cmdLen),
        .addr    (memAddr),
        .last_c  (last_c)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    load = 1'b1;
                    if (cmdLen == '0)  state_d = DONE;
                    else if (cmdRW)    state_d = RD_ISSUE;
                    else               state_d = WR_WAIT;
                end
            end
            RD_ISSUE: state_d = RD_CAPT;
            RD_CAPT:  state_d = RD_HOLD;
            RD_HOLD: begin
                if (rdReady) begin
                    step    = 1'b1;
                    state_d = last_c ? DONE : RD_ISSUE;
                end
            end
            WR_WAIT: begin
                if (wrValid) state_d = WR_ISSUE;
            end
            WR_ISSUE: begin
                step    = 1'b1;
                state_d = last_c ? DONE : WR_WAIT;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Status outputs are registered decodes of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cmdReady <= 1'b1;
            rdValid  <= 1'b0;
            wrReady  <= 1'b0;
            done     <= 1'b0;
            memEN    <= 1'b0;
            memRW    <= 1'b1;
            rdData   <= '0;
            memWrite <= '0;
        end else begin
            state_q  <= state_d;
            cmdReady <= (state_d == IDLE);
            rdValid  <= (state_d == RD_HOLD);
            wrReady  <= (state_d == WR_WAIT);
            done     <= (state_d == DONE);
            memEN    <= (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
            memRW    <= (state_d != WR_ISSUE);
            if (state_q == RD_CAPT) begin
                rdData <= memBus;
            end
            if ((state_q == WR_WAIT) && wrValid) begin
                memWrite <= wrData;
            end
        end
    end

endmodule

// File: tb/tb_mem_xfer.sv
// Randomized and directed bench for mem_xfer against a transaction-level reference of the memory contents.
module tb_mem_xfer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmdValid;
    logic         cmdReady;
    logic         cmdRW;
    logic [7:0]   cmdBase;
    logic [3:0]   cmdLen;
    logic [255:0] rdData;
    logic         rdValid;
    logic         rdReady = 1'b0;
    logic [255:0] wrData;
    logic         wrValid;
    logic         wrReady;
    logic         done;
    logic [7:0]   memAddr;
    logic         memRW;
    logic         memEN;
    logic [255:0] memWrite;
    logic [255:0] memBus;

    typedef struct {
        int           cyc;
        logic [7:0]   addr;
        logic         rw;
        logic [255:0] data;
    } acc_t;

    typedef struct {
        int           cyc;
        logic [255:0] data;
    } rd_t;

    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           excl_bad = 0;
    int           rd_mode = 0;
    int           hs_cyc = 0;
    logic [255:0] mem     [256];
    logic [255:0] ref_mem [256];
    logic [255:0] wr_words [16];
    acc_t         acc_q [$];
    rd_t          rd_q  [$];
    int           wh_q  [$];
    int           done_q [$];

    mem_xfer dut (
        .clk      (clk),
        .rst      (rst),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdRW    (cmdRW),
        .cmdBase  (cmdBase),
        .cmdLen   (cmdLen),
        .rdData   (rdData),
        .rdValid  (rdValid),
        .rdReady  (rdReady),
        .wrData   (wrData),
        .wrValid  (wrValid),
        .wrReady  (wrReady),
        .done     (done),
        .memAddr  (memAddr),
        .memRW    (memRW),
        .memEN    (memEN),
        .memWrite (memWrite),
        .memBus   (memBus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: access sampled on the memEN edge, read data appears on memBus for the next edge
    initial begin
        #1;
        for (int i = 0; i < 256; i++) mem[i] = ref_mem[i];
        forever begin
            @(posedge clk);
            if (memEN) begin
                if (memRW) memBus <= mem[memAddr];
                else       mem[memAddr] <= memWrite;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_mode == 0)      rdReady = 1'b1;
        else if (rd_mode == 1) rdReady = 1'($urandom_range(0, 1));
        else                   rdReady = 1'b0;
    end

    always @(negedge clk) begin
        if (memEN) acc_q.push_back('{cyc, memAddr, memRW, memWrite});
        if (rdValid && rdReady) rd_q.push_back('{cyc, rdData});
        if (wrValid && wrReady) wh_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (rdValid && wrReady) excl_bad++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [7:0] base, input logic [3:0] len);
        int k;
        cmdValid = 1'b1;
        cmdRW    = rw;
        cmdBase  = base;
        cmdLen   = len;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmdReady && k < 100);
        if (!cmdReady) check("cmd_timeout", 0, 1);
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        cmdBase  = 8'($urandom);
        cmdLen   = 4'($urandom);
        cmdRW    = 1'($urandom);
    endtask

    task automatic feed_writes(input int n, input int wdelay);
        int d;
        int k;
        for (int i = 0; i < n; i++) begin
            d = (wdelay < 0) ? int'($urandom_range(0, 3)) : wdelay;
            if (d > 0) begin
                repeat (d) @(posedge clk);
                #1;
            end
            wrValid = 1'b1;
            wrData  = wr_words[i];
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!wrReady && k < 200);
            if (!wrReady) check("wr_timeout", 0, 1);
            @(posedge clk);
            #1;
            wrValid = 1'b0;
            wrData  = {8{$urandom}};
        end
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        k = 0;
        while (done_q.size() == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_q.size() == d0) check("done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Expected behaviour of one command, derived from the transfer rules and the reference memory
    task automatic check_cmd(input logic rw, input logic [7:0] base, input int len, input int mode,
                             input int a0, input int r0, input int w0, input int d0);
        int na, nr, nw, nd;
        logic [7:0] a;
        acc_t e;
        na = acc_q.size() - a0;
        nr = rd_q.size() - r0;
        nw = wh_q.size() - w0;
        nd = done_q.size() - d0;
        check("n_access", na, len);
        check("n_done", nd, 1);
        check("n_rd_hs", nr, rw ? len : 0);
        check("n_wr_hs", nw, rw ? 0 : len);
        if (na != len || nd != 1 || nr != (rw ? len : 0) || nw != (rw ? 0 : len)) return;
        if (len == 0) begin
            check("done_len0", done_q[d0], hs_cyc + 1);
            return;
        end
        for (int i = 0; i < len; i++) begin
            e = acc_q[a0 + i];
            a = 8'(base + 8'(i));
            check("addr", e.addr, a);
            check("rw", e.rw, rw);
            if (rw) begin
                check("rdata", rd_q[r0 + i].data, ref_mem[a]);
                if (i == 0) check("rd_first", e.cyc, hs_cyc + 1);
                else        check("rd_reissue", e.cyc, rd_q[r0 + i - 1].cyc + 1);
                if (mode == 0 && i > 0) check("rd_spacing", e.cyc - acc_q[a0 + i - 1].cyc, 3);
            end else begin
                check("wdata", e.data, wr_words[i]);
                check("wr_issue", e.cyc, wh_q[w0 + i] + 1);
                ref_mem[a] = wr_words[i];
            end
        end
        if (rw) check("done_rd", done_q[d0], rd_q[r0 + len - 1].cyc + 1);
        else    check("done_wr", done_q[d0], acc_q[a0 + len - 1].cyc + 1);
    endtask

    task automatic xfer(input logic rw, input logic [7:0] base, input int len, input int mode,
                        input int wdelay);
        int a0, r0, w0, d0;
        @(negedge clk);
        rd_mode = mode;
        a0 = acc_q.size();
        r0 = rd_q.size();
        w0 = wh_q.size();
        d0 = done_q.size();
        @(posedge clk);
        #1;
        fork
            begin
                issue(rw, base, 4'(len));
                wait_done(d0, 3000);
            end
            begin
                if (!rw) feed_writes(len, wdelay);
            end
        join
        check_cmd(rw, base, len, mode, a0, r0, w0, d0);
    endtask

    task automatic hold_watch();
        int k;
        int a;
        logic [255:0] d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rdValid && k < 50);
        check("hold_seen", rdValid, 1);
        d = rdData;
        a = acc_q.size();
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", rdValid, 1);
            check("hold_data", rdData, d);
        end
        check("hold_no_access", acc_q.size() - a, 0);
        rd_mode = 0;
    endtask

    task automatic reset_mid_read();
        int k, r0, d0, a1;
        @(negedge clk);
        rd_mode = 0;
        r0 = rd_q.size();
        d0 = done_q.size();
        @(posedge clk);
        #1;
        issue(1'b1, 8'h80, 4'd4);
        k = 0;
        while (rd_q.size() - r0 < 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        rd_mode = 2;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rdValid && k < 50);
        check("rst_in_hold", rdValid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmdready", cmdReady, 1);
        check("rst_rdvalid", rdValid, 0);
        check("rst_memen", memEN, 0);
        a1 = acc_q.size();
        repeat (10) @(negedge clk);
        check("rst_no_access", acc_q.size() - a1, 0);
        check("rst_no_done", done_q.size() - d0, 0);
        rd_mode = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int d0;
        int len;
        for (int i = 0; i < 256; i++) ref_mem[i] = {8{$urandom}};
        rst      = 1'b1;
        cmdValid = 1'b1;
        cmdRW    = 1'b1;
        cmdBase  = 8'h00;
        cmdLen   = 4'd0;
        wrValid  = 1'b0;
        wrData   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmdready", cmdReady, 1);
        check("reset_rdvalid", rdValid, 0);
        check("reset_wrready", wrReady, 0);
        check("reset_done", done, 0);
        check("reset_memen", memEN, 0);
        check("reset_memrw", memRW, 1);
        check("reset_memaddr", memAddr, 0);
        check("reset_memwrite", memWrite, 0);
        check("reset_rddata", rdData, 0);
        d0 = done_q.size();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cmdValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("cmd_during_rst", done_q.size() - d0, 0);

        xfer(1'b1, 8'h02, 3, 0, 0);

        fork
            xfer(1'b1, 8'h40, 2, 2, 0);
            hold_watch();
        join

        wr_words[0] = {32{8'hAA}};
        wr_words[1] = {32{8'h55}};
        xfer(1'b0, 8'h05, 2, 1, 4);
        xfer(1'b1, 8'h05, 2, 0, 0);

        xfer(1'b1, 8'hFE, 3, 0, 0);

        xfer(1'b1, 8'h10, 0, 0, 0);
        xfer(1'b0, 8'h20, 0, 1, 0);

        reset_mid_read();

        repeat (30) begin
            len = int'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) wr_words[i] = {8{$urandom}};
            xfer(1'($urandom), 8'($urandom), len, int'($urandom_range(0, 1)), -1);
        end

        xfer(1'b0, 8'hFE, 3, 1, 0);
        xfer(1'b1, 8'hFE, 3, 1, 0);

        check("rdvalid_wrready_excl", excl_bad, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
